// File: rtl/div_pkg.sv
// Shared types and constants for the iterative radix-4 divider.
package div_pkg;

    localparam int DIV_WIDTH   = 16;
    localparam int DIV_LATENCY = DIV_WIDTH / 2 + 3;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/radix4_div_step.sv
// Combinational double restoring step: retires two quotient bits per call.
module radix4_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] dvs_mag,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0]   rem_mid;
    logic [WIDTH-1:0] q_mid;

    // Returns {next_rem, next_q}; the extra top bit keeps the trial compare exact.
    function automatic logic [2*WIDTH:0] restore_step(
        input logic [WIDTH:0]   r,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH+1:0] r_sh;
        logic [WIDTH+1:0] diff;
        r_sh = {r, q[WIDTH-1]};
        diff = r_sh - {2'b00, d};
        if (r_sh < {2'b00, d}) begin
            return {r_sh[WIDTH:0], q[WIDTH-2:0], 1'b0};
        end
        return {diff[WIDTH:0], q[WIDTH-2:0], 1'b1};
    endfunction

    always_comb begin
        {rem_mid, q_mid} = restore_step(rem_in, q_in, dvs_mag);
        {rem_out, q_out} = restore_step(rem_mid, q_mid, dvs_mag);
    end

endmodule

// File: rtl/radix4_divider_16bit.sv
// Iterative radix-4 signed/unsigned divider with valid/ready handshakes
// and a fixed latency regardless of operand values.
module radix4_divider_16bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic             signed_q, signed_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_q;

    radix4_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .q_in    (quo_q),
        .dvs_mag (dvs_mag_q),
        .rem_out (step_rem),
        .q_out   (step_q)
    );

    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        signed_d    = signed_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dvs_mag_d   = dvs_mag_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        iter_cnt_d  = iter_cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dividend_d = dividend;
                    divisor_d  = divisor;
                    signed_d   = is_signed;
                    state_d    = PREP;
                end
            end
            // The most-negative value is its own magnitude when read as unsigned.
            PREP: begin
                q_neg_d    = signed_q & (dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1]);
                r_neg_d    = signed_q & dividend_q[WIDTH-1];
                dvs_mag_d  = (signed_q && divisor_q[WIDTH-1]) ? -divisor_q : divisor_q;
                quo_d      = (signed_q && dividend_q[WIDTH-1]) ? -dividend_q : dividend_q;
                rem_d      = '0;
                iter_cnt_d = CNT_W'(WIDTH / 2 - 1);
                state_d    = ITER;
            end
            ITER: begin
                rem_d = step_rem;
                quo_d = step_q;
                if (iter_cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    iter_cnt_d = iter_cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                if (divisor_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dividend_q;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = q_neg_q ? -quo_q : quo_q;
                    remainder_d = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    dbz_d       = 1'b0;
                end
                state_d = DONE;
            end
            // One cycle to raise out_valid, then hold until the consumer accepts.
            DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dividend_q  <= '0;
            divisor_q   <= '0;
            signed_q    <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dvs_mag_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            iter_cnt_q  <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            signed_q    <= signed_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            dvs_mag_q   <= dvs_mag_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            iter_cnt_q  <= iter_cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
